// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - core-side bus of the interrupt controller: mask, acknowledge, irq vector, pending
interface irq_controller_if;
    logic        mask_we;
    logic [6:0]  mask_wdata;
    logic        irq_ack;
    logic [4:0]  irq_ack_id;
    logic [31:0] irq;
    logic [4:0]  irq_id;
    logic [6:0]  pending;

    modport master (
        output mask_we, mask_wdata, irq_ack, irq_ack_id,
        input  irq, irq_id, pending
    );

    modport slave (
        input  mask_we, mask_wdata, irq_ack, irq_ack_id,
        output irq, irq_id, pending
    );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - synchronise, debounce and edge-detect board sources; deliver one acked interrupt at a time
module irq_controller #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       btn,
    input  logic             uart_int,
    input  logic             eth_1_int,
    input  logic             eth_2_int,
    irq_controller_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    // Source vector uses the pending bit map: [3:0] btn, [4] eth_2, [5] eth_1, [6] uart
    logic [6:0]    raw, meta, sync, lvl, lvl_q, ev;
    logic [3:0]    deb;
    logic [CW-1:0] cnt [4];
    logic [6:0]    pend, pend_next, mask, elig, cur_sel, win_sel, clr;
    logic [1:0]    state;
    logic [31:0]   irq_q;
    logic [4:0]    id_q, win_id;
    logic          ack_match;

    assign raw = {uart_int, eth_1_int, eth_2_int, btn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign lvl = {sync[6:4], deb};
    assign ev  = lvl & ~lvl_q;

    assign ack_match = (state == ST_ASSERT) && bus.irq_ack && (bus.irq_ack_id == id_q);
    assign clr       = ack_match ? cur_sel : '0;
    // A new edge on the bit being acknowledged wins, so it is re-delivered
    assign pend_next = (pend & ~clr) | ev;

    always_comb begin
        win_sel = '0;
        win_id  = '0;
        if (elig[6])      begin win_sel = 7'h40; win_id = 5'd31; end
        else if (elig[5]) begin win_sel = 7'h20; win_id = 5'd29; end
        else if (elig[4]) begin win_sel = 7'h10; win_id = 5'd28; end
        else if (elig[3]) begin win_sel = 7'h08; win_id = 5'd3;  end
        else if (elig[2]) begin win_sel = 7'h04; win_id = 5'd2;  end
        else if (elig[1]) begin win_sel = 7'h02; win_id = 5'd1;  end
        else if (elig[0]) begin win_sel = 7'h01; win_id = 5'd0;  end
    end

    // elig is registered from pend_next and the pre-write mask, so a mask write
    // at edge m reaches the selection at m+1 and irq at m+2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= '0;
            pend    <= '0;
            mask    <= 7'h7F;
            elig    <= '0;
            state   <= ST_IDLE;
            irq_q   <= '0;
            id_q    <= '0;
            cur_sel <= '0;
        end else begin
            lvl_q <= lvl;
            pend  <= pend_next;
            elig  <= pend_next & mask;
            if (bus.mask_we) mask <= bus.mask_wdata;
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        irq_q   <= 32'd1 << win_id;
                        id_q    <= win_id;
                        cur_sel <= win_sel;
                        state   <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (ack_match) begin
                        irq_q   <= '0;
                        id_q    <= '0;
                        cur_sel <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.irq     = irq_q;
    assign bus.irq_id  = id_q;
    assign bus.pending = pend;
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - randomized scoreboard bench for irq_controller against a behavioural model
module tb_irq_controller;
    localparam int D    = 16;
    localparam int HMAX = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = '0;
    logic       uart_int = 1'b0;
    logic       eth_1_int = 1'b0;
    logic       eth_2_int = 1'b0;

    irq_controller_if bus();

    irq_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .uart_int (uart_int),
        .eth_1_int(eth_1_int),
        .eth_2_int(eth_2_int),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int edge_n;
        int id;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int src_id(input int s);
        case (s)
            4:       return 28;
            5:       return 29;
            6:       return 31;
            default: return s;
        endcase
    endfunction

    // Reference model: raw input history per source since reset, evaluated with window rules
    bit         raw_h [7][HMAX];
    int         e = 0;
    logic [6:0] m_pend = '0, m_mask = 7'h7F, m_elig = '0, m_raw, m_ev, m_clr;
    logic [3:0] m_deb = '0, m_deb_prev = '0;
    int         m_cur = -1;
    bit         m_gap = 1'b0;
    bit         flip;

    function automatic bit rh(input int s, input int i);
        if (i < 0 || i >= HMAX) return 1'b0;
        return raw_h[s][i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0; m_pend = '0; m_mask = 7'h7F; m_elig = '0;
            m_deb = '0; m_deb_prev = '0; m_cur = -1; m_gap = 1'b0;
            exp_q.delete();
        end else begin
            m_raw = {uart_int, eth_1_int, eth_2_int, btn};
            if (e < HMAX) for (int s = 0; s < 7; s++) raw_h[s][e] = m_raw[s];
            m_ev = '0;
            for (int s = 4; s < 7; s++) m_ev[s] = rh(s, e - 2) & ~rh(s, e - 3);
            for (int b = 0; b < 4; b++) m_ev[b] = m_deb[b] & ~m_deb_prev[b];
            m_deb_prev = m_deb;
            // Button level accepted once the synchronised level has differed for D consecutive edges
            for (int b = 0; b < 4; b++) begin
                flip = 1'b1;
                for (int j = e - D - 1; j <= e - 2; j++)
                    if (rh(b, j) == m_deb[b]) flip = 1'b0;
                if (flip) m_deb[b] = ~m_deb[b];
            end
            m_clr = '0;
            if (m_cur >= 0) begin
                if (bus.irq_ack && int'(bus.irq_ack_id) == src_id(m_cur)) begin
                    m_clr[m_cur] = 1'b1;
                    m_cur = -1;
                    m_gap = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_elig != 0) begin
                for (int s = 0; s < 7; s++) if (m_elig[s]) m_cur = s;
                exp_q.push_back('{e, src_id(m_cur)});
            end
            m_pend = (m_pend & ~m_clr) | m_ev;
            m_elig = m_pend & m_mask;
            if (bus.mask_we) m_mask = bus.mask_wdata;
            e++;
        end
    end

    logic [31:0] prev_irq = '0;
    exp_t        got;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pending", {25'd0, bus.pending}, {25'd0, m_pend});
            chk("irq", bus.irq, (m_cur >= 0) ? (32'd1 << src_id(m_cur)) : 32'd0);
            chk("irq_id", {27'd0, bus.irq_id}, (m_cur >= 0) ? 32'(src_id(m_cur)) : 32'd0);
            if (prev_irq == 0 && bus.irq != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_irq", bus.irq, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk("sb_id", {27'd0, bus.irq_id}, 32'(got.id));
                    chk("sb_vec", bus.irq, 32'd1 << got.id);
                    chk("sb_edge", 32'(e - 1), 32'(got.edge_n));
                end
            end
            prev_irq = bus.irq;
        end else begin
            prev_irq = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit rnd);
        int pick;
        tick();
        bus.irq_ack = 1'b0;
        bus.mask_we = 1'b0;
        if (bus.irq != 0 && $urandom_range(0, 3) == 0) begin
            bus.irq_ack = 1'b1;
            pick = $urandom_range(0, 5);
            bus.irq_ack_id = (pick == 0) ? 5'($urandom_range(0, 31)) : bus.irq_id;
        end else if ($urandom_range(0, 19) == 0) begin
            bus.irq_ack = 1'b1;
            bus.irq_ack_id = 5'($urandom_range(0, 31));
        end
        if (rnd) begin
            if ($urandom_range(0, 11) == 0) uart_int = ~uart_int;
            if ($urandom_range(0, 11) == 0) eth_1_int = ~eth_1_int;
            if ($urandom_range(0, 11) == 0) eth_2_int = ~eth_2_int;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 24) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 29) == 0) begin
                bus.mask_we = 1'b1;
                bus.mask_wdata = $urandom_range(0, 1) ? 7'h7F : 7'($urandom_range(0, 127));
            end
        end
    endtask

    initial begin
        bit seen;
        bus.mask_we = 1'b0; bus.mask_wdata = '0;
        bus.irq_ack = 1'b0; bus.irq_ack_id = '0;
        repeat (3) tick();
        chk("rst_irq", bus.irq, 32'd0);
        chk("rst_pending", {25'd0, bus.pending}, 32'd0);
        rst_n = 1'b1;

        uart_int = 1'b1;
        repeat (3) step(1'b0);
        uart_int = 1'b0;
        repeat (30) step(1'b0);

        eth_1_int = 1'b1; eth_2_int = 1'b1;
        repeat (40) step(1'b0);
        eth_1_int = 1'b0; eth_2_int = 1'b0;

        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) btn[2] = ~btn[2];
            step(1'b0);
        end
        btn[2] = 1'b1;
        repeat (40) step(1'b0);

        bus.mask_we = 1'b1; bus.mask_wdata = 7'h3F;
        uart_int = 1'b1;
        repeat (20) step(1'b0);
        bus.mask_we = 1'b1; bus.mask_wdata = 7'h7F;
        repeat (20) step(1'b0);
        uart_int = 1'b0;

        repeat (2500) step(1'b1);

        uart_int = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            step(1'b0);
            if (bus.irq != 0) seen = 1'b1;
        end
        chk("wait_irq_before_reset", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_irq", bus.irq, 32'd0);
        chk("async_rst_irq_id", {27'd0, bus.irq_id}, 32'd0);
        chk("async_rst_pending", {25'd0, bus.pending}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        repeat (1500) step(1'b1);

        uart_int = 1'b0; eth_1_int = 1'b0; eth_2_int = 1'b0; btn = '0;
        bus.mask_we = 1'b0;
        repeat (300) step(1'b0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
